// File: rtl/aes128_dec_stream_if_if.sv
// Bus bundle for aes128_dec_stream_if: ciphertext input stream, plaintext output
// stream and the decryptor start/ready/done handshake.
interface aes128_dec_stream_if_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_data_o;
  logic         dec_start_o;
  logic [127:0] dec_key_o;
  logic [127:0] dec_cipher_o;
  logic         dec_ready_i;
  logic         dec_done_i;
  logic [127:0] dec_plain_i;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, dec_ready_i, dec_done_i, dec_plain_i,
    output in_ready_o, out_valid_o, out_data_o, dec_start_o, dec_key_o, dec_cipher_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i, dec_ready_i, dec_done_i, dec_plain_i,
    input  in_ready_o, out_valid_o, out_data_o, dec_start_o, dec_key_o, dec_cipher_o
  );
endinterface

// File: rtl/aes128_dec_stream_if.sv
// Word-stream packer/unpacker around an AES-128 block decryptor.
// Define AES_DEC_CBC_EN to add CBC chaining; default build is ECB.
module aes128_dec_stream_if #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         key_i,
  input  logic [127:0]         iv_i,
  input  logic                 iv_load_i,
  aes128_dec_stream_if_if.slave bus,
  output logic [CNT_W-1:0]     blk_cnt_o,
  output logic                 err_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] COLLECT_S = 2'd0;
  localparam logic [1:0] ISSUE_S   = 2'd1;
  localparam logic [1:0] WAIT_S    = 2'd2;
  localparam logic [1:0] DRAIN_S   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [1:0]       r_idx;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_start;
  logic             r_err;
  logic [127:0]     r_cipher;
  logic [127:0]     r_result;
  logic [127:0]     w_result;
  logic [CNT_W-1:0] r_blk_cnt;
  logic             w_in_acc;
  logic             w_out_hs;
  logic             w_tmo_hit;
  logic             w_iv_load;
  logic             w_done;

  assign w_in_acc  = bus.in_valid_i & r_in_ready;
  assign w_out_hs  = r_out_valid & bus.out_ready_i;
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign w_done    = (r_state == WAIT_S) & bus.dec_done_i;
  assign w_iv_load = iv_load_i & (r_state == COLLECT_S) & (r_idx == 2'd0);

`ifdef AES_DEC_CBC_EN
  logic [127:0] r_chain;

  // Chain register: previous ciphertext block, or the IV after a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= 128'd0;
    end else if (w_done) begin
      r_chain <= r_cipher;
    end else if (w_iv_load) begin
      r_chain <= iv_i;
    end else begin
      r_chain <= r_chain;
    end
  end

  assign w_result = bus.dec_plain_i ^ r_chain;
`else
  logic w_unused_iv;
  assign w_unused_iv = ^iv_i;
  assign w_result    = bus.dec_plain_i;
`endif

  // Next-state selection
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      COLLECT_S: begin
        if (w_in_acc && (r_idx == 2'd3)) w_state_nx = ISSUE_S;
        else                             w_state_nx = COLLECT_S;
      end
      ISSUE_S: begin
        if (bus.dec_ready_i) w_state_nx = WAIT_S;
        else                 w_state_nx = ISSUE_S;
      end
      WAIT_S: begin
        if (bus.dec_done_i)  w_state_nx = DRAIN_S;
        else if (w_tmo_hit)  w_state_nx = COLLECT_S;
        else                 w_state_nx = WAIT_S;
      end
      DRAIN_S: begin
        if (w_out_hs && (r_idx == 2'd3)) w_state_nx = COLLECT_S;
        else                             w_state_nx = DRAIN_S;
      end
      default: w_state_nx = COLLECT_S;
    endcase
  end

  // Datapath, handshake flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT_S;
      r_idx       <= 2'd0;
      r_tmo_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_err       <= 1'b0;
      r_cipher    <= 128'd0;
      r_result    <= 128'd0;
      r_blk_cnt   <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx == COLLECT_S);
      r_start    <= 1'b0;
      case (r_state)
        COLLECT_S: begin
          if (w_in_acc) begin
            r_cipher[8'd127 - {1'b0, r_idx, 5'd0} -: 32] <= bus.in_data_i;
            r_idx <= r_idx + 2'd1;
          end
          // iv_load also serves as the error acknowledge, in both modes
          if (w_iv_load) r_err <= 1'b0;
        end
        ISSUE_S: begin
          if (bus.dec_ready_i) begin
            r_start   <= 1'b1;
            r_tmo_cnt <= '0;
          end
        end
        WAIT_S: begin
          if (bus.dec_done_i) begin
            r_result    <= w_result;
            r_out_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        DRAIN_S: begin
          // Shifting leaves the next word on top and all-zero after the 4th
          if (w_out_hs) begin
            r_result <= {r_result[95:0], 32'd0};
            r_idx    <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_out_valid <= 1'b0;
              r_blk_cnt   <= r_blk_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= COLLECT_S;
      endcase
    end
  end

  assign bus.in_ready_o   = r_in_ready;
  assign bus.out_valid_o  = r_out_valid;
  assign bus.out_data_o   = r_result[127:96];
  assign bus.dec_start_o  = r_start;
  assign bus.dec_key_o    = key_i;
  assign bus.dec_cipher_o = r_cipher;
  assign blk_cnt_o        = r_blk_cnt;
  assign err_o            = r_err;

endmodule

// File: tb/tb_aes128_dec_stream_if.sv
// Directed + randomized bench for aes128_dec_stream_if with a block-level
// reference model (ECB, or CBC when AES_DEC_CBC_EN is defined).
module tb_aes128_dec_stream_if;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_i = 128'd0;
  logic [127:0] iv_i = 128'd0;
  logic         iv_load_i = 1'b0;
  logic [15:0]  blk_cnt_o;
  logic         err_o;

  aes128_dec_stream_if_if bus();

  aes128_dec_stream_if #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .iv_i(iv_i), .iv_load_i(iv_load_i),
    .bus(bus), .blk_cnt_o(blk_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int m_blk = 0;
  logic [127:0] m_chain = 128'd0;

  always @(posedge clk) if (bus.dec_start_o === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input logic [127:0] c, input int first, input int last);
    int n;
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = c[127-32*i -: 32];
      n = 0;
      while (bus.in_ready_o !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      check("in_ready_bound", 128'(n < 100), 128'd1);
      tick();
      bus.in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (bus.dec_start_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("start_seen", 128'(bus.dec_start_o), 128'd1);
  endtask

  // mode 0: random out_ready, mode 1: 1-0-0-1 then 1s
  task automatic drain(input logic [127:0] e, input int mode);
    int k, j, n;
    logic r;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0; j = 0; n = 0;
    while (k < 4 && n < 200) begin
      if (bus.out_valid_o === 1'b1) begin
        check("out_word", 128'(bus.out_data_o), 128'(e[127-32*k -: 32]));
        check("in_ready_drain", 128'(bus.in_ready_o), 128'd0);
        if (mode == 1) r = (j < 4) ? pat[3-j] : 1'b1;
        else           r = 1'($urandom_range(0, 1));
        j++;
        bus.out_ready_i = r;
        tick();
        if (r) k++;
      end else begin
        bus.out_ready_i = 1'($urandom_range(0, 1));
        tick();
      end
      n++;
    end
    bus.out_ready_i = 1'b0;
    check("handshakes", 128'(k), 128'd4);
    check("valid_after_drain", 128'(bus.out_valid_o), 128'd0);
    m_blk++;
    check("blk_cnt", 128'(blk_cnt_o), 128'(m_blk));
  endtask

  task automatic run_block(input logic [127:0] c, input logic [127:0] p, input int lat,
                           input int mode, input bit busy);
    int sc0;
    logic [127:0] e;
    sc0 = start_cnt;
    if (busy) bus.dec_ready_i = 1'b0;
    send_words(c, 0, 3);
    if (busy) begin
      for (int i = 0; i < 20; i++) begin
        check("no_start_busy", 128'(bus.dec_start_o), 128'd0);
        tick();
      end
      check("in_ready_busy", 128'(bus.in_ready_o), 128'd0);
      bus.dec_ready_i = 1'b1;
    end
    wait_start();
    check("dec_cipher", bus.dec_cipher_o, c);
    check("dec_key", bus.dec_key_o, key_i);
    tick();
    check("start_one_cycle", 128'(bus.dec_start_o), 128'd0);
    repeat (lat - 1) tick();
    bus.dec_plain_i = p;
    bus.dec_done_i  = 1'b1;
    tick();
    bus.dec_done_i  = 1'b0;
    check("first_word_latency", 128'(bus.out_valid_o), 128'd1);
`ifdef AES_DEC_CBC_EN
    e = p ^ m_chain;
    m_chain = c;
`else
    e = p;
`endif
    drain(e, mode);
    check("start_count", 128'(start_cnt - sc0), 128'd1);
  endtask

  initial begin
    logic [127:0] c, p;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 32'd0;
    bus.out_ready_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    bus.dec_done_i  = 1'b0;
    bus.dec_plain_i = 128'd0;
    key_i = 128'h000102030405060708090a0b0c0d0e0f;

    // Reset state
    tick(); tick();
    check("rst_in_ready", 128'(bus.in_ready_o), 128'd0);
    check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("rst_out_data", 128'(bus.out_data_o), 128'd0);
    check("rst_start", 128'(bus.dec_start_o), 128'd0);
    check("rst_cipher", bus.dec_cipher_o, 128'd0);
    check("rst_blk_cnt", 128'(blk_cnt_o), 128'd0);
    check("rst_err", 128'(err_o), 128'd0);
    check("rst_key", bus.dec_key_o, key_i);
    rst_n = 1'b1;
    tick();

    // FIPS-197 single block
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 3, 0, 1'b0);

    // Output backpressure 1-0-0-1
    run_block({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 2, 1, 1'b0);

    // Decryptor busy for 20 cycles
    run_block({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 1, 0, 1'b1);

    // Timeout: done never comes
    c = {$urandom, $urandom, $urandom, $urandom};
    send_words(c, 0, 3);
    wait_start();
    repeat (7) tick();
    check("tmo_err_early", 128'(err_o), 128'd0);
    check("tmo_in_ready_early", 128'(bus.in_ready_o), 128'd0);
    tick();
    check("tmo_err", 128'(err_o), 128'd1);
    check("tmo_collect", 128'(bus.in_ready_o), 128'd1);
    check("tmo_blk_cnt", 128'(blk_cnt_o), 128'(m_blk));
    bus.dec_done_i = 1'b1;
    tick();
    bus.dec_done_i = 1'b0;
    check("late_done_ignored", 128'(bus.out_valid_o), 128'd0);
    check("err_sticky", 128'(err_o), 128'd1);
    iv_i = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load_i = 1'b1;
    tick();
    iv_load_i = 1'b0;
`ifdef AES_DEC_CBC_EN
    m_chain = iv_i;
`endif
    check("iv_load_clears_err", 128'(err_o), 128'd0);

    // Two chained blocks after the IV load
    run_block({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 2, 0, 1'b0);
    run_block({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 4, 0, 1'b0);

    // iv_load mid-block must be ignored
    c = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send_words(c, 0, 0);
    iv_i = {$urandom, $urandom, $urandom, $urandom};
    iv_load_i = 1'b1;
    tick();
    iv_load_i = 1'b0;
    send_words(c, 1, 3);
    wait_start();
    check("midblock_cipher", bus.dec_cipher_o, c);
    tick();
    bus.dec_plain_i = p;
    bus.dec_done_i = 1'b1;
    tick();
    bus.dec_done_i = 1'b0;
`ifdef AES_DEC_CBC_EN
    drain(p ^ m_chain, 0);
    m_chain = c;
`else
    drain(p, 0);
`endif

    // Randomized blocks with random keys and latencies
    for (int b = 0; b < 6; b++) begin
      key_i = {$urandom, $urandom, $urandom, $urandom};
      run_block({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(1, 6), 0, 1'($urandom_range(0, 3) == 0));
    end

    // Reset after two words of a block
    c = {$urandom, $urandom, $urandom, $urandom};
    send_words(c, 0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(bus.in_ready_o), 128'd0);
    check("mid_rst_cipher", bus.dec_cipher_o, 128'd0);
    check("mid_rst_blk_cnt", 128'(blk_cnt_o), 128'd0);
    check("mid_rst_start", 128'(bus.dec_start_o), 128'd0);
    tick();
    rst_n = 1'b1;
    m_blk = 0;
    m_chain = 128'd0;
    tick();
    run_block({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes128_dec_stream_if.md
Name: aes128_dec_stream_if

Overview:
- Streaming front/back end for the AES-128 block decryptor.
- Packs 32-bit ciphertext words from a valid/ready stream into a 128-bit block and launches the decryptor via its start/ready/done handshake.
- Captures the 128-bit plaintext and unpacks it onto a 32-bit valid/ready output stream.
- Optionally applies CBC chaining. Sits between the bus-side DMA/FIFO and the decryptor core.

Parameters:
- TIMEOUT_CYC, 1023: max cycles in WAIT_S before abort; min 1; counter width = $clog2(TIMEOUT_CYC+1).
- CNT_W, 16: width of blk_cnt_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_i  in  128  cipher key, forwarded unregistered to dec_key_o
- iv_i  in  128  CBC initial vector
- iv_load_i  in  1  pulse: load iv_i into chain register
- in_valid_i  in  1  ciphertext word valid
- in_ready_o  out  1  ciphertext word accepted when valid&ready
- in_data_i  in  32  ciphertext word; first word of a block = bits [127:96]
- out_valid_o  out  1  plaintext word valid
- out_ready_i  in  1  downstream accepts word
- out_data_o  out  32  plaintext word; first word = bits [127:96]
- dec_start_o  out  1  one-cycle start pulse to decryptor
- dec_key_o  out  128  key to decryptor (= key_i)
- dec_cipher_o  out  128  assembled ciphertext block, registered
- dec_ready_i  in  1  decryptor idle
- dec_done_i  in  1  one-cycle pulse, plaintext valid
- dec_plain_i  in  128  decryptor plaintext
- blk_cnt_o  out  CNT_W  completed blocks, wraps to 0 after all-ones
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0 except dec_key_o (= key_i). Word index, chain register, timeout counter and state (COLLECT_S) are also reset.
- COLLECT_S:
  - in_ready_o=1.
  - On each accepted word, shift it into dec_cipher_o at slot [127-32*idx -: 32] and increment idx (2-bit).
  - On acceptance of the 4th word (idx==3): go to ISSUE_S, idx wraps to 0.
- ISSUE_S:
  - in_ready_o=0.
  - When dec_ready_i=1: assert dec_start_o for exactly 1 cycle, clear the timeout counter, go to WAIT_S.
  - While dec_ready_i=0: hold with no pulse.
- WAIT_S:
  - Timeout counter increments each cycle.
  - On dec_done_i: register result = dec_plain_i (XOR chain, see feature), go to DRAIN_S.
  - If the counter reaches TIMEOUT_CYC before done: set err_o, discard the block, go to COLLECT_S. blk_cnt_o does not increment.
  - dec_done_i in any other state is ignored.
- DRAIN_S:
  - out_valid_o=1, out_data_o = result word idx.
  - Data held stable while out_valid_o & !out_ready_i.
  - On each handshake idx increments. After the 4th handshake: out_valid_o=0 next cycle, blk_cnt_o+1, go to COLLECT_S.
- Latency: first output word is valid the cycle after the dec_done_i sample.
- No overlap: the next block is not collected until the current block fully drains.
- err_o is cleared only by reset or by iv_load_i.
- iv_load_i:
  - Honoured only in COLLECT_S with idx==0; ignored elsewhere.
  - Same-cycle input word acceptance is still honoured.
- Reset mid-operation: immediate return to COLLECT_S, partial block discarded, dec_start_o deasserted.

Optional Feature:
- AES_DEC_CBC_EN defined:
  - result = dec_plain_i ^ chain.
  - On done, chain <= dec_cipher_o (current block's ciphertext). On iv_load_i, chain <= iv_i.
  - On timeout, chain is unchanged.
- Undefined: ECB mode. result = dec_plain_i; iv_i/iv_load_i ignored; no chain register synthesized.

Test Plan:
- ECB single block, FIPS-197:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
  - Response: one dec_start_o pulse; dec_cipher_o=69c4e0d86a7b0430d8cdb78070b4c55a; model done returns 00112233445566778899aabbccddeeff; out words 00112233,44556677,8899aabb,ccddeeff; blk_cnt_o=1.
- Backpressure:
  - Stimulus: out_ready_i toggled 1-0-0-1 during drain.
  - Response: out_data_o stable across stalls; exactly 4 handshakes; in_ready_o stays 0 until drain completes.
- Decryptor busy:
  - Stimulus: dec_ready_i=0 for 20 cycles after the 4th word.
  - Response: no dec_start_o until dec_ready_i=1; then a 1-cycle pulse.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; dec_done_i never asserted.
  - Response: err_o=1 eight cycles after start; state back to COLLECT_S; blk_cnt_o unchanged; iv_load_i clears err_o.
- CBC (AES_DEC_CBC_EN), two blocks:
  - Stimulus: IV=000102030405060708090a0b0c0d0e0f; model returns P' for each block.
  - Response: block 1 out = P'^IV; block 2 out = P'^C1, where C1 = block 1 ciphertext.
- Reset mid-block:
  - Stimulus: rst_n low after 2 words accepted.
  - Response: all outputs 0; the next 4 words form a fresh block, starting at bits [127:96].
